rec_play_ctrl: RTL and testbench
================================

REC_PLAY_CTRL -- requirements
Module: rec_play_ctrl

Parameters
REQ-001 ADDRESS_WIDTH, default 8, SHALL set RAM address width; depth = 2**ADDRESS_WIDTH.
REQ-002 DATA_WIDTH, default 8, SHALL set sample and RAM data width.

Interface
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 start_rec  in  1  SHALL request recording; honoured only in IDLE.
REQ-006 start_play  in  1  SHALL request playback; honoured only in IDLE.
REQ-007 stop  in  1  SHALL abort RECORD or PLAY back to IDLE.
REQ-008 loop  in  1  SHALL select wrap-around playback when high, sampled each play step.
REQ-009 sample_en  in  1  SHALL be the sample-rate strobe; one RAM access per strobe.
REQ-010 sample_in  in  DATA_WIDTH  SHALL be the sample to record.
REQ-011 ram_wr_en, ram_rd_en  out  1  SHALL drive RAM write/read enables.
REQ-012 ram_wr_addr, ram_rd_addr  out  ADDRESS_WIDTH  SHALL drive RAM addresses.
REQ-013 ram_din  out  DATA_WIDTH  SHALL drive RAM write data.
REQ-014 ram_dout  in  DATA_WIDTH  SHALL be RAM read data (1-cycle synchronous read).
REQ-015 sample_out  out  DATA_WIDTH  SHALL carry played-back sample.
REQ-016 sample_valid  out  1  SHALL qualify sample_out for one cycle.
REQ-017 busy  out  1  SHALL be high whenever state is not IDLE.
REQ-018 done  out  1  SHALL pulse one cycle on any RECORD/PLAY to IDLE transition.
REQ-019 length  out  ADDRESS_WIDTH+1  SHALL report samples held (0..2**ADDRESS_WIDTH).

Function
REQ-020 FSM states SHALL be IDLE, RECORD, PLAY.
REQ-021 IDLE: start_rec -> RECORD with wr_ptr=0, length=0; start_rec wins over simultaneous start_play.
REQ-022 IDLE: start_play with length!=0 -> PLAY with rd_ptr=0; with length==0 ignored, stay IDLE, no done.
REQ-023 RECORD: sample_en && !stop SHALL combinationally assert ram_wr_en, ram_wr_addr=wr_ptr, ram_din=sample_in; next edge wr_ptr+1, length+1.
REQ-024 RECORD: write at address 2**ADDRESS_WIDTH-1 SHALL end recording -> IDLE, length=2**ADDRESS_WIDTH, done pulse; wr_ptr wraps to 0.
REQ-025 PLAY: sample_en && !stop SHALL combinationally assert ram_rd_en, ram_rd_addr=rd_ptr.
REQ-026 PLAY step at rd_ptr==length-1: loop=1 -> rd_ptr=0, stay PLAY; loop=0 -> IDLE, done pulse.
REQ-027 Otherwise each play step SHALL increment rd_ptr.
REQ-028 sample_valid SHALL be ram_rd_en delayed one cycle; sample_out SHALL equal ram_dout in that cycle, held otherwise.
REQ-029 stop in RECORD/PLAY SHALL take priority over same-cycle sample_en: no RAM access, -> IDLE, done pulse; length keeps samples already written.
REQ-030 stop, start_rec, start_play in states where not honoured SHALL be ignored.
REQ-031 ram_wr_en and ram_rd_en SHALL never both be high; both low in IDLE.
REQ-032 sample_valid from the final play read SHALL still fire in the cycle after PLAY exits.

Reset
REQ-033 rst SHALL force IDLE, wr_ptr=rd_ptr=0, length=0, sample_out=0, sample_valid=0, done=0 at next edge, from any state.
REQ-034 rst SHALL override all inputs in the same cycle; no done pulse from reset-abort; pending sample_valid suppressed.

Verification (ADDRESS_WIDTH=4, DATA_WIDTH=8)
REQ-035 start_rec, 5 strobes with 0x11..0x15, stop -> writes addr 0..4, length=5, done one cycle, busy low after.
REQ-036 Then start_play, loop=0, 5 strobes -> sample_valid 5 times, sample_out 0x11..0x15 one cycle after each read, done after 5th.
REQ-037 Record 16 strobes with no stop -> auto IDLE after addr 15, length=16, done; 17th strobe produces no write.
REQ-038 length=3, loop=1, 7 strobes -> rd_addr 0,1,2,0,1,2,0, stays PLAY; clear loop at rd_ptr=2 -> IDLE and done after that read.
REQ-039 Same-cycle start_rec+start_play -> RECORD; start_play with length=0 -> stays IDLE, no done.
REQ-040 rst mid-PLAY on a strobe cycle -> next cycle IDLE, length=0, sample_valid=0, done=0.

Source files
------------

// File: rtl/rec_play_ctrl.sv
// Record/playback sequencer: streams strobed samples into a single-port-per-direction
// RAM, then replays them once or in a loop. RAM has a 1-cycle synchronous read.
module rec_play_ctrl #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_rec,
  input  logic                     start_play,
  input  logic                     stop,
  input  logic                     loop,
  input  logic                     sample_en,
  input  logic [DATA_WIDTH-1:0]    sample_in,
  output logic                     ram_wr_en,
  output logic                     ram_rd_en,
  output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
  output logic [ADDRESS_WIDTH-1:0] ram_rd_addr,
  output logic [DATA_WIDTH-1:0]    ram_din,
  input  logic [DATA_WIDTH-1:0]    ram_dout,
  output logic [DATA_WIDTH-1:0]    sample_out,
  output logic                     sample_valid,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH:0]   length,
  output logic [1:0]               dbg_state
);

  localparam int LW = ADDRESS_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RECORD = 2'd1, S_PLAY = 2'd2} state_t;

  state_t                   state_q;
  logic [ADDRESS_WIDTH-1:0] wr_ptr_q;
  logic [ADDRESS_WIDTH-1:0] rd_ptr_q;
  logic [LW-1:0]            length_q;
  logic [DATA_WIDTH-1:0]    hold_q;
  logic                     sample_valid_q;
  logic                     done_q;

  logic          rec_step;
  logic          play_step;
  logic          last_wr;
  logic          last_rd;
  logic [LW-1:0] len_m1;

  // Reset gates the RAM strobes so a reset cycle never issues an access.
  assign rec_step  = (state_q == S_RECORD) && sample_en && !stop && !rst;
  assign play_step = (state_q == S_PLAY)   && sample_en && !stop && !rst;
  assign last_wr   = (wr_ptr_q == {ADDRESS_WIDTH{1'b1}});
  assign len_m1    = length_q - LW'(1);
  assign last_rd   = ({1'b0, rd_ptr_q} == len_m1);

  assign ram_wr_en    = rec_step;
  assign ram_rd_en    = play_step;
  assign ram_wr_addr  = wr_ptr_q;
  assign ram_rd_addr  = rd_ptr_q;
  assign ram_din      = sample_in;
  assign sample_valid = sample_valid_q;
  // Read data is only present on the bus in the cycle after the read; hold it afterwards.
  assign sample_out   = sample_valid_q ? ram_dout : hold_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign length       = length_q;
  assign dbg_state    = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      length_q       <= '0;
      hold_q         <= '0;
      sample_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      sample_valid_q <= play_step;
      done_q         <= 1'b0;
      if (sample_valid_q) hold_q <= ram_dout;
      case (state_q)
        S_IDLE: begin
          if (start_rec) begin
            state_q  <= S_RECORD;
            wr_ptr_q <= '0;
            length_q <= '0;
          end else if (start_play && (length_q != '0)) begin
            state_q  <= S_PLAY;
            rd_ptr_q <= '0;
          end
        end
        S_RECORD: begin
          if (stop) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end else if (sample_en) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            length_q <= length_q + LW'(1);
            if (last_wr) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        S_PLAY: begin
          if (stop) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end else if (sample_en) begin
            if (last_rd) begin
              rd_ptr_q <= '0;
              if (!loop) begin
                state_q <= S_IDLE;
                done_q  <= 1'b1;
              end
            end else begin
              rd_ptr_q <= rd_ptr_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Bench for rec_play_ctrl: directed scenarios then random traffic, against a
// queue-based model of recorded samples; playback data checked via a scoreboard.
module tb_rec_play_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_rec = 1'b0, start_play = 1'b0, stop = 1'b0, loop = 1'b0;
  logic          sample_en = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic          ram_wr_en, ram_rd_en;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic [DW-1:0] sample_out;
  logic          sample_valid, busy, done;
  logic [AW:0]   length;
  logic [1:0]    dbg_state;

  rec_play_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start_rec(start_rec), .start_play(start_play),
    .stop(stop), .loop(loop), .sample_en(sample_en), .sample_in(sample_in),
    .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
    .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr),
    .ram_din(ram_din), .ram_dout(ram_dout),
    .sample_out(sample_out), .sample_valid(sample_valid),
    .busy(busy), .done(done), .length(length), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // RAM with a one-cycle synchronous read
  logic [DW-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    ram_dout = '0;
  end
  always @(posedge clk) begin
    if (ram_rd_en === 1'b1) ram_dout <= mem[ram_rd_addr];
    if (ram_wr_en === 1'b1) mem[ram_wr_addr] <= ram_din;
  end

  // checking counters
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  // reference model: recorded samples as a queue, mode, play position
  typedef enum int {M_IDLE, M_REC, M_PLAY} mode_t;
  mode_t         m_mode  = M_IDLE;
  logic [DW-1:0] m_rec[$];
  int            m_idx   = 0;
  logic          m_done  = 1'b0;
  logic          m_valid = 1'b0;
  logic [DW-1:0] exp_q[$];
  bit            mon_on  = 1'b0;

  // monitor: every presented playback sample is matched against the scoreboard
  always @(negedge clk) begin
    if (mon_on && sample_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_sample_valid", 32'(sample_out), 32'hFFFF_FFFF);
      else chk("sample_out", 32'(sample_out), 32'(exp_q.pop_front()));
    end
  end

  task automatic step(input logic r, input logic sr, input logic sp, input logic st,
                      input logic lp, input logic se, input logic [DW-1:0] din);
    logic exp_wr, exp_rd;
    @(posedge clk);
    #1;
    rst = r; start_rec = sr; start_play = sp; stop = st; loop = lp;
    sample_en = se; sample_in = din;
    @(negedge clk);
    // registered outputs reflect the model after the previous step
    chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
    chk("done", 32'(done), 32'(m_done));
    chk("length", 32'(length), 32'(m_rec.size()));
    chk("sample_valid", 32'(sample_valid), 32'(m_valid));
    exp_wr = !r && m_mode == M_REC  && se && !st;
    exp_rd = !r && m_mode == M_PLAY && se && !st;
    chk("ram_wr_en", 32'(ram_wr_en), 32'(exp_wr));
    chk("ram_rd_en", 32'(ram_rd_en), 32'(exp_rd));
    if (exp_wr) begin
      chk("ram_wr_addr", 32'(ram_wr_addr), 32'(m_rec.size()));
      chk("ram_din", 32'(ram_din), 32'(din));
    end
    if (exp_rd) chk("ram_rd_addr", 32'(ram_rd_addr), 32'(m_idx));
    // advance the model
    m_done = 1'b0;
    if (r) begin
      m_mode = M_IDLE; m_rec.delete(); m_idx = 0; m_valid = 1'b0;
    end else begin
      m_valid = exp_rd;
      if (exp_rd) exp_q.push_back(m_rec[m_idx]);
      case (m_mode)
        M_IDLE: begin
          if (sr) begin m_mode = M_REC; m_rec.delete(); end
          else if (sp && m_rec.size() != 0) begin m_mode = M_PLAY; m_idx = 0; end
        end
        M_REC: begin
          if (st) begin m_mode = M_IDLE; m_done = 1'b1; end
          else if (se) begin
            m_rec.push_back(din);
            if (m_rec.size() == DEPTH) begin m_mode = M_IDLE; m_done = 1'b1; end
          end
        end
        M_PLAY: begin
          if (st) begin m_mode = M_IDLE; m_done = 1'b1; end
          else if (se) begin
            if (m_idx == m_rec.size() - 1) begin
              m_idx = 0;
              if (!lp) begin m_mode = M_IDLE; m_done = 1'b1; end
            end else m_idx++;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic strobe(input logic lp, input logic [DW-1:0] din);
    step(1'b0, 1'b0, 1'b0, 1'b0, lp, 1'b1, din);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    mon_on = 1'b1;
    idle(2);

    // record five samples then stop
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) strobe(1'b0, 8'(8'h11 + i));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(2);
    chk("len_after_rec5", 32'(length), 32'd5);

    // single-shot playback of those five
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) strobe(1'b0, 8'h00);
    idle(3);

    // full-depth record ends by itself; the extra strobe must not write
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < DEPTH + 1; i++) strobe(1'b0, 8'($urandom_range(0, 255)));
    idle(2);
    chk("len_full", 32'(length), 32'(DEPTH));

    // three-sample loop, then drop loop on the last entry
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) strobe(1'b0, 8'(8'hA0 + i));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) strobe(1'b1, 8'h00);
    strobe(1'b1, 8'h00);
    strobe(1'b0, 8'h00);
    idle(2);

    // simultaneous starts pick record; empty playback is ignored
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(2);

    // reset on a playback strobe
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) strobe(1'b0, 8'(8'h50 + i));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    strobe(1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    idle(2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 199) == 0),
           1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) < 6),
           8'($urandom_range(0, 255)));
    end
    idle(3);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
